mul_pipe_hs: RTL and testbench
==============================

# mul_pipe_hs

Parametrised pipelined multiplier with valid/ready handshake, per-operand signedness and an optional accumulate mode. It is the next generation of the single-cycle combinational `mul_*` cores in the generated datapath. It registers the product over `NUM_STAGE` cycles and tolerates downstream backpressure without losing or duplicating data. Throughput is one product per cycle when downstream is ready.

## Interface
- `din0_WIDTH`, default 6: width of operand 0.
- `din1_WIDTH`, default 4: width of operand 1.
- `dout_WIDTH`, default 10: result width.
- `NUM_STAGE`, default 2: pipeline depth. Legal range 1..4.
- `SIGNED0`, default 1: 1 treats din0 as two's complement, 0 as unsigned.
- `SIGNED1`, default 1: same rule for din1.
- `ACC_MODE`, default 0: 1 makes dout a running sum of products.

- `clk`  in  1  the single clock. All state is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `din_vld`  in  1  operands are valid.
- `din_rdy`  out  1  the block can accept operands this cycle.
- `din0`  in  din0_WIDTH  operand 0.
- `din1`  in  din1_WIDTH  operand 1.
- `acc_clr`  in  1  sampled with the operands. In ACC_MODE, restarts the sum from this product. Ignored when ACC_MODE=0.
- `dout_vld`  out  1  the result is valid.
- `dout_rdy`  in  1  downstream accepts the result.
- `dout`  out  dout_WIDTH  the product, or the accumulated sum in ACC_MODE.

## Operation
- Full product P = ext(din0) * ext(din1), computed at width din0_WIDTH+din1_WIDTH.
  - ext() sign-extends when the operand's SIGNED parameter is 1, and zero-extends otherwise.
- P is sized to dout_WIDTH before it enters the stage-1 register:
  - If dout_WIDTH is smaller, keep the LSBs.
  - If dout_WIDTH is larger, extend: sign-extend if either SIGNED0 or SIGNED1 is 1, else zero-extend.
- Pipeline structure:
  - Stages 1..NUM_STAGE each hold a valid bit, a data word and (in ACC_MODE) a clr flag.
  - Stage 1 captures the sized product and acc_clr.
  - Stages 2..N copy the data from the previous stage.
- Transfers:
  - Input transfer occurs when din_vld && din_rdy.
  - Output transfer occurs when dout_vld && dout_rdy.
- Stall rule, with bubble collapse:
  - Stage k may load when it is empty, or when its content moves on in the same cycle.
  - din_rdy = stage 1 may load. din_rdy depends on dout_rdy combinationally through the chain; there is no skid buffer.
  - A stage that cannot advance holds its data and valid bit unchanged.
- ACC_MODE=1:
  - The last stage is the accumulator. When it loads, data = (clr ? 0 : acc) + incoming, wrapping modulo 2^dout_WIDTH.
  - acc is the last-stage data register. It keeps its value after the output is popped.
  - acc resets to 0, so the first product after reset needs no clr.
  - With NUM_STAGE=1, the accumulate happens in the stage-1 load.
- ACC_MODE=0: the last stage just copies its input.

## Timing
- Reset (reset_n low, asynchronous): all valid bits = 0, data = 0, acc = 0.
  - Outputs during reset: dout_vld = 0, dout = 0, din_rdy = 1.
  - Deassertion is synchronised externally. The block adds no reset synchroniser.
- Latency: an operand accepted at edge t gives dout_vld=1 after edge t+NUM_STAGE-1, i.e. visible in the cycle after the NUM_STAGE-th capture edge. The result is NUM_STAGE register stages deep.
- With dout_rdy held high, one result per cycle and no bubbles.
- Full pipeline with dout_rdy=0: din_rdy=0 in the same cycle. Nothing is overwritten.
- dout_rdy rising on a full pipeline: output pops, everything shifts, and din_rdy=1 in that same cycle.
- While dout_vld=1 and dout_rdy=0: dout is stable, and dout_vld stays high until the transfer.
- Reset asserted mid-operation: all in-flight results are discarded immediately and acc is cleared.

## Test plan
- Signed, defaults (6s x 4s -> 10, NUM_STAGE=2): din0=6'h20 (-32), din1=4'h7 (7) -> dout=10'h320 (-224), dout_vld two cycles after acceptance.
- SIGNED0=SIGNED1=0: din0=6'h3F, din1=4'hF -> dout=10'h3B1 (945). Also -1 x -1 under signed -> 10'h001.
- Back-to-back stream of 8 operand pairs with dout_rdy=1 -> 8 consecutive dout_vld cycles, correct order, din_rdy never drops.
- Backpressure: dout_rdy=0 for 5 cycles while feeding -> din_rdy falls after NUM_STAGE accepts, dout held stable; release -> all products delivered in order, none lost or duplicated.
- ACC_MODE=1: (3,4,clr=1), (5,6,clr=0), (2,2,clr=1) -> dout = 12, 42, 4.
- Assert reset_n low with 2 results in flight -> dout_vld=0 and dout=0 immediately. After release, the next accumulation starts from 0.

Source files
------------

// File: rtl/mul_pipe_hs.sv
// Pipelined multiplier with a valid/ready handshake, per-operand signedness and optional accumulation.
// Each stage can load when it is empty or its content moves on, so bubbles collapse under backpressure.
module mul_pipe_hs #(
  parameter int din0_WIDTH = 6,
  parameter int din1_WIDTH = 4,
  parameter int dout_WIDTH = 10,
  parameter int NUM_STAGE  = 2,
  parameter int SIGNED0    = 1,
  parameter int SIGNED1    = 1,
  parameter int ACC_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  din_vld,
  output logic                  din_rdy,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  acc_clr,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic [dout_WIDTH-1:0] dout
);

  localparam int PW   = din0_WIDTH + din1_WIDTH;
  localparam int LAST = NUM_STAGE - 1;

  logic [PW-1:0]         ext0, ext1, prod;
  logic [dout_WIDTH-1:0] sized;

  assign ext0 = (SIGNED0 != 0) ? {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0}
                               : {{din1_WIDTH{1'b0}}, din0};
  assign ext1 = (SIGNED1 != 0) ? {{din0_WIDTH{din1[din1_WIDTH-1]}}, din1}
                               : {{din0_WIDTH{1'b0}}, din1};
  // The low PW bits of a PW x PW product are identical for signed and unsigned operands.
  assign prod = ext0 * ext1;

  generate
    if (dout_WIDTH <= PW) begin : g_trunc
      assign sized = prod[dout_WIDTH-1:0];
    end else begin : g_ext
      localparam bit SX = (SIGNED0 != 0) || (SIGNED1 != 0);
      assign sized = {{(dout_WIDTH - PW){SX & prod[PW-1]}}, prod};
    end
  endgenerate

  logic [NUM_STAGE-1:0]  vld_q;
  logic [NUM_STAGE-1:0]  ld;
  logic [dout_WIDTH-1:0] data_q  [NUM_STAGE];
  logic                  clr_q   [NUM_STAGE];
  logic [dout_WIDTH-1:0] in_data [NUM_STAGE];
  logic                  in_vld  [NUM_STAGE];
  logic                  in_clr  [NUM_STAGE];
  logic [dout_WIDTH-1:0] acc_base;
  logic [dout_WIDTH-1:0] acc_sum;

  // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
  always_comb begin
    logic chain;
    chain = dout_rdy;
    for (int k = NUM_STAGE - 1; k >= 0; k--) begin
      chain = chain || !vld_q[k];
      ld[k] = chain;
    end

    in_vld[0]  = din_vld;
    in_data[0] = sized;
    in_clr[0]  = acc_clr;
    for (int k = 1; k < NUM_STAGE; k++) begin
      in_vld[k]  = vld_q[k-1];
      in_data[k] = data_q[k-1];
      in_clr[k]  = clr_q[k-1];
    end

    acc_base = ((ACC_MODE != 0) && !in_clr[LAST]) ? data_q[LAST] : '0;
    acc_sum  = acc_base + in_data[LAST];
  end

  // NOTE: the stage data array is reset explicitly because dout and the accumulator must read 0 after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      for (int k = 0; k < NUM_STAGE; k++) begin
        data_q[k] <= '0;
        clr_q[k]  <= 1'b0;
      end
    end else begin
      // NOTE: non-blocking assignments so every stage samples its neighbour's pre-edge value.
      for (int k = 0; k < NUM_STAGE; k++) begin
        if (ld[k]) begin
          vld_q[k] <= in_vld[k];
          if (in_vld[k]) begin
            data_q[k] <= (k == LAST) ? acc_sum : in_data[k];
            clr_q[k]  <= in_clr[k];
          end
        end
      end
    end
  end

  assign din_rdy  = ld[0];
  assign dout_vld = vld_q[LAST];
  assign dout     = data_q[LAST];

endmodule

// File: tb/tb_mul_pipe_hs.sv
// Scoreboard bench for mul_pipe_hs: signed, unsigned and accumulating instances share one stimulus stream.
module tb_mul_pipe_hs;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       din_vld;
  logic [5:0] din0;
  logic [3:0] din1;
  logic       acc_clr;
  logic       dout_rdy;

  logic       din_rdy_s, din_rdy_u, din_rdy_a;
  logic       dout_vld_s, dout_vld_u, dout_vld_a;
  logic [9:0] dout_s, dout_u, dout_a;

  logic [9:0] q_s[$], q_u[$], q_a[$];
  logic [9:0] acc_m;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         pops_s   = 0;

  always #5 clk = ~clk;

  mul_pipe_hs u_s (
    .clk(clk), .reset_n(reset_n), .din_vld(din_vld), .din_rdy(din_rdy_s),
    .din0(din0), .din1(din1), .acc_clr(acc_clr),
    .dout_vld(dout_vld_s), .dout_rdy(dout_rdy), .dout(dout_s)
  );

  mul_pipe_hs #(.SIGNED0(0), .SIGNED1(0)) u_u (
    .clk(clk), .reset_n(reset_n), .din_vld(din_vld), .din_rdy(din_rdy_u),
    .din0(din0), .din1(din1), .acc_clr(acc_clr),
    .dout_vld(dout_vld_u), .dout_rdy(dout_rdy), .dout(dout_u)
  );

  mul_pipe_hs #(.ACC_MODE(1)) u_a (
    .clk(clk), .reset_n(reset_n), .din_vld(din_vld), .din_rdy(din_rdy_a),
    .din0(din0), .din1(din1), .acc_clr(acc_clr),
    .dout_vld(dout_vld_a), .dout_rdy(dout_rdy), .dout(dout_a)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [9:0] prod_m(input logic [5:0] a, input logic [3:0] b, input bit sgn);
    int ia, ib;
    ia = sgn ? int'($signed(a)) : int'(a);
    ib = sgn ? int'($signed(b)) : int'(b);
    return 10'(ia * ib);
  endfunction

  // One clock cycle: drive at the falling edge, then evaluate both handshakes before the rising edge.
  task automatic cycle(input logic v, input logic [5:0] a, input logic [3:0] b,
                       input logic c, input logic r);
    @(negedge clk);
    din_vld = v; din0 = a; din1 = b; acc_clr = c; dout_rdy = r;
    #1;
    if (din_vld && din_rdy_s) q_s.push_back(prod_m(din0, din1, 1'b1));
    if (din_vld && din_rdy_u) q_u.push_back(prod_m(din0, din1, 1'b0));
    if (din_vld && din_rdy_a) begin
      acc_m = (acc_clr ? 10'd0 : acc_m) + prod_m(din0, din1, 1'b1);
      q_a.push_back(acc_m);
    end
    if (dout_vld_s && !dout_rdy && q_s.size() > 0) check("s_hold", dout_s, q_s[0]);
    if (dout_vld_s && dout_rdy) begin
      check("s_have_exp", q_s.size() > 0, 1);
      if (q_s.size() > 0) begin check("s_data", dout_s, q_s.pop_front()); pops_s++; end
    end
    if (dout_vld_u && dout_rdy) begin
      check("u_have_exp", q_u.size() > 0, 1);
      if (q_u.size() > 0) check("u_data", dout_u, q_u.pop_front());
    end
    if (dout_vld_a && dout_rdy) begin
      check("a_have_exp", q_a.size() > 0, 1);
      if (q_a.size() > 0) check("a_data", dout_a, q_a.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 6'd0, 4'd0, 1'b0, 1'b1);
  endtask

  initial begin
    int p0;
    reset_n = 1'b0; din_vld = 1'b0; din0 = '0; din1 = '0; acc_clr = 1'b0; dout_rdy = 1'b1;
    acc_m = '0;
    #12;
    check("rst_vld", {dout_vld_s, dout_vld_u, dout_vld_a}, 3'b000);
    check("rst_dout", {dout_s, dout_u, dout_a}, 30'd0);
    check("rst_rdy", {din_rdy_s, din_rdy_u, din_rdy_a}, 3'b111);
    @(negedge clk); reset_n = 1'b1;

    // Latency and signed product: -32 * 7 = -224.
    cycle(1'b1, 6'h20, 4'h7, 1'b1, 1'b1);
    cycle(1'b0, 6'h00, 4'h0, 1'b0, 1'b1);
    check("lat_early", dout_vld_s, 1'b0);
    cycle(1'b0, 6'h00, 4'h0, 1'b0, 1'b1);
    check("lat_vld", dout_vld_s, 1'b1);
    check("lat_signed", dout_s, 10'h320);

    // 63 * 15 unsigned and -1 * -1 signed.
    cycle(1'b1, 6'h3F, 4'hF, 1'b0, 1'b1);
    cycle(1'b0, 6'h00, 4'h0, 1'b0, 1'b1);
    cycle(1'b0, 6'h00, 4'h0, 1'b0, 1'b1);
    check("unsigned_max", dout_u, 10'h3B1);
    check("signed_m1m1", dout_s, 10'h001);
    idle(2);

    // Back-to-back stream of 8 with no backpressure.
    p0 = pops_s;
    for (int i = 0; i < 10; i++) begin
      cycle(i < 8, 6'($urandom), 4'($urandom), 1'($urandom), 1'b1);
      if (i < 8)  check("stream_rdy", din_rdy_s, 1'b1);
      if (i >= 2) check("stream_vld", dout_vld_s, 1'b1);
    end
    idle(2);
    check("stream_count", pops_s - p0, 8);

    // Backpressure: 5 stalled cycles, then release and drain.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 6'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      check("bp_rdy", din_rdy_s, i < 2);
      if (i >= 2) check("bp_vld", dout_vld_s, 1'b1);
    end
    cycle(1'b1, 6'($urandom), 4'($urandom), 1'($urandom), 1'b1);
    check("bp_release_rdy", din_rdy_s, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'($urandom), 4'($urandom), 1'($urandom), 1'b1);
    idle(4);
    check("bp_drained_s", q_s.size(), 0);
    check("bp_drained_a", q_a.size(), 0);
    check("bp_empty", dout_vld_s, 1'b0);

    // Accumulation: 3*4 (clr), +5*6, 2*2 (clr) -> 12, 42, 4.
    cycle(1'b1, 6'd3, 4'd4, 1'b1, 1'b1);
    cycle(1'b1, 6'd5, 4'd6, 1'b0, 1'b1);
    cycle(1'b1, 6'd2, 4'd2, 1'b1, 1'b1);
    check("acc_0", dout_a, 10'd12);
    cycle(1'b0, 6'd0, 4'd0, 1'b0, 1'b1);
    check("acc_1", dout_a, 10'd42);
    cycle(1'b0, 6'd0, 4'd0, 1'b0, 1'b1);
    check("acc_2", dout_a, 10'd4);
    idle(2);

    // Reset with two results in flight.
    cycle(1'b1, 6'd7, 4'd3, 1'b0, 1'b0);
    cycle(1'b1, 6'd9, 4'd5, 1'b0, 1'b0);
    @(posedge clk); #2;
    din_vld = 1'b0;
    check("pre_rst_vld", dout_vld_s, 1'b1);
    reset_n = 1'b0;
    #1;
    check("midrst_vld", {dout_vld_s, dout_vld_u, dout_vld_a}, 3'b000);
    check("midrst_dout", {dout_s, dout_u, dout_a}, 30'd0);
    check("midrst_rdy", din_rdy_s, 1'b1);
    q_s.delete(); q_u.delete(); q_a.delete();
    acc_m = '0;
    @(negedge clk); reset_n = 1'b1;

    // Accumulator restarts from zero without clr: 2*3 = 6.
    cycle(1'b1, 6'd2, 4'd3, 1'b0, 1'b1);
    cycle(1'b0, 6'd0, 4'd0, 1'b0, 1'b1);
    cycle(1'b0, 6'd0, 4'd0, 1'b0, 1'b1);
    check("post_rst_acc", dout_a, 10'd6);
    idle(3);
    check("final_empty", q_s.size() + q_u.size() + q_a.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
